// File: rtl/harz_req_sequencer.sv
// -----------------------------------------------------------------------------
// harz_req_sequencer
//
// Upstream master of the HARZ80 bus. Host-side commands are queued in a
// command FIFO and issued one at a time on the request/busy handshake toward
// the MMU stage. Read data comes back through a response FIFO. If the MMU
// never completes a transaction, the transaction is aborted and a sticky
// timeout flag is raised.
//
// Optional feature (macro HARZQ_BURST_EN):
//   defined   - each entry also stores i_cmd_len and is repeated len+1 times.
//               MEM kinds step the address by one per beat, wrapping at FFFF.
//               IO kinds keep the address fixed.
//   undefined - i_cmd_len is ignored and every entry is one transaction.
//
// o_request encoding (harz_req_t):
//   0 = HARZ80_NONE, 1 = IO_WRITE, 2 = IO_READ, 3 = MEM_WRITE, 4 = MEM_READ
//
// Ports:
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready/i_cmd_kind/i_cmd_addr/i_cmd_data/i_cmd_len
//                         command push side (kind 0=IO_WR 1=IO_RD 2=MEM_WR 3=MEM_RD)
//   o_rsp_valid/i_rsp_ready/o_rsp_data/o_rsp_err
//                         response pop side (head entry, err=1 means timed out)
//   o_request/o_address/o_write_data/i_read_data/i_busy
//                         HARZ80 master port toward the MMU
//   o_idle                command FIFO empty and FSM idle
//   o_timeout_err/i_err_clr  sticky timeout flag and its clear
// -----------------------------------------------------------------------------
module harz_req_sequencer #(
    parameter int CMD_DEPTH      = 8,
    parameter int RSP_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_kind,
    input  logic [15:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_data,
    input  logic [7:0]  i_cmd_len,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [7:0]  o_rsp_data,
    output logic        o_rsp_err,
    output logic [2:0]  o_request,
    output logic [15:0] o_address,
    output logic [7:0]  o_write_data,
    input  logic [7:0]  i_read_data,
    input  logic        i_busy,
    output logic        o_idle,
    output logic        o_timeout_err,
    input  logic        i_err_clr
);

    localparam logic [2:0] REQ_NONE = 3'd0;

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CAW:0]  C_ONE   = (CAW+1)'(1);
    localparam logic [RAW:0]  R_ONE   = (RAW+1)'(1);

`ifdef HARZQ_BURST_EN
    localparam int CW = 34;   // {len, kind, addr, data}
`else
    localparam int CW = 26;   // {kind, addr, data}
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Command FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [CW-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW:0]  cmd_wr, cmd_rd;
    logic          cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [CW-1:0] cmd_din, head;
    logic [1:0]    head_kind;
    logic [15:0]   head_addr;
    logic [7:0]    head_data;
    logic          head_is_read;

    assign cmd_empty = (cmd_wr == cmd_rd);
    assign cmd_full  = (cmd_wr[CAW] != cmd_rd[CAW]) &&
                       (cmd_wr[CAW-1:0] == cmd_rd[CAW-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign o_cmd_ready = !cmd_full || cmd_pop;
    assign cmd_push    = i_cmd_valid && o_cmd_ready;

`ifdef HARZQ_BURST_EN
    assign cmd_din = {i_cmd_len, i_cmd_kind, i_cmd_addr, i_cmd_data};
`else
    assign cmd_din = {i_cmd_kind, i_cmd_addr, i_cmd_data};
    logic unused_len;
    assign unused_len = ^i_cmd_len;
`endif

    assign head         = cmd_mem[cmd_rd[CAW-1:0]];
    assign head_kind    = head[25:24];
    assign head_addr    = head[23:8];
    assign head_data    = head[7:0];
    assign head_is_read = head_kind[0];

    always_ff @(posedge i_CLK) begin
        if (cmd_push) cmd_mem[cmd_wr[CAW-1:0]] <= cmd_din;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cmd_wr <= '0;
            cmd_rd <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + C_ONE;
            if (cmd_pop)  cmd_rd <= cmd_rd + C_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO: entry = {err, data}
    // ------------------------------------------------------------------
    logic [8:0]   rsp_mem [RSP_DEPTH];
    logic [RAW:0] rsp_wr, rsp_rd;
    logic         rsp_empty, rsp_full, rsp_push, rsp_pop;
    logic [8:0]   rsp_din, rsp_head;

    assign rsp_empty   = (rsp_wr == rsp_rd);
    assign rsp_full    = (rsp_wr[RAW] != rsp_rd[RAW]) &&
                         (rsp_wr[RAW-1:0] == rsp_rd[RAW-1:0]);
    assign o_rsp_valid = !rsp_empty;
    assign rsp_pop     = o_rsp_valid && i_rsp_ready;
    assign rsp_head    = rsp_mem[rsp_rd[RAW-1:0]];
    // Gate the head so the outputs read zero while the FIFO is empty.
    assign o_rsp_data  = o_rsp_valid ? rsp_head[7:0] : 8'h00;
    assign o_rsp_err   = o_rsp_valid && rsp_head[8];

    always_ff @(posedge i_CLK) begin
        if (rsp_push) rsp_mem[rsp_wr[RAW-1:0]] <= rsp_din;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rsp_wr <= '0;
            rsp_rd <= '0;
        end else begin
            if (rsp_push) rsp_wr <= rsp_wr + R_ONE;
            if (rsp_pop)  rsp_rd <= rsp_rd + R_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Transaction control
    // ------------------------------------------------------------------
    logic [TW-1:0] tcnt;
    logic          tmo, done, beat_last, can_issue;
    logic [15:0]   issue_addr;
    logic [2:0]    req_map;

    assign tmo  = ((state == S_ISSUE) || (state == S_WAIT)) && (tcnt == T_LIMIT);
    assign done = (state == S_WAIT) && !i_busy && !tmo;

    // Only one transaction is ever in flight and it completes before the FSM
    // returns to IDLE, so "space counting in-flight reads" reduces to not-full.
    assign can_issue = !cmd_empty && (!head_is_read || !rsp_full);

    assign req_map = {1'b0, head_kind} + 3'd1;

`ifdef HARZQ_BURST_EN
    logic [7:0] beat_idx;
    logic [7:0] head_len;

    assign head_len   = head[33:26];
    assign beat_last  = (beat_idx == head_len);
    // MEM kinds advance per beat; the 16-bit add wraps FFFF -> 0000.
    assign issue_addr = head_kind[1] ? (head_addr + {8'h00, beat_idx}) : head_addr;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            beat_idx <= 8'h00;
        end else if (tmo) begin
            beat_idx <= 8'h00;          // abort remaining beats
        end else if (done) begin
            beat_idx <= beat_last ? 8'h00 : beat_idx + 8'd1;
        end
    end
`else
    assign beat_last  = 1'b1;
    assign issue_addr = head_addr;
`endif

    assign cmd_pop  = (done && beat_last) || tmo;
    assign rsp_push = (done || tmo) && head_is_read;
    assign rsp_din  = tmo ? {1'b1, 8'hFF} : {1'b0, i_read_data};

    assign o_idle = cmd_empty && (state == S_IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (i_RST) state <= S_IDLE;
        else       state <= state_nx;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (can_issue) state_nx = S_ISSUE;
            S_ISSUE: begin
                if (tmo)         state_nx = S_GAP;
                else if (i_busy) state_nx = S_WAIT;
            end
            S_WAIT:  if (tmo || !i_busy) state_nx = S_GAP;
            S_GAP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: registered outputs and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_request     <= REQ_NONE;
            o_address     <= 16'h0000;
            o_write_data  <= 8'h00;
            o_timeout_err <= 1'b0;
            tcnt          <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (can_issue) begin
                        o_request    <= req_map;
                        o_address    <= issue_addr;
                        o_write_data <= head_data;
                        tcnt         <= '0;
                    end
                end
                S_ISSUE: begin
                    tcnt <= tcnt + TW'(1);
                    // Request is held across stale busy=0: the MMU only
                    // samples it once it is back in its own idle state.
                    if (tmo || i_busy) o_request <= REQ_NONE;
                end
                S_WAIT:  tcnt <= tcnt + TW'(1);
                default: ;
            endcase

            // A timeout in the same cycle as a clear keeps the flag set.
            if (tmo)            o_timeout_err <= 1'b1;
            else if (i_err_clr) o_timeout_err <= 1'b0;
        end
    end

endmodule

// File: doc/harz_req_sequencer.md
Name: harz_req_sequencer

Overview:
- Upstream master of the HARZ80 bus. Queues host-side transaction commands (from the command/serial decoder) and issues them one at a time on the harzbus request/busy handshake into the MMU stage.
- Returns read data through a response FIFO.
- Provides a sticky timeout error if the MMU never completes a transaction.

Parameters:
- CMD_DEPTH, 8, command FIFO entries (power of 2, ≥2)
- RSP_DEPTH, 8, response FIFO entries (power of 2, ≥2)
- TIMEOUT_CYCLES, 1024, i_CLK cycles allowed per transaction before abort (≥4)

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  synchronous reset, active-high
- i_cmd_valid  in  1  command push strobe
- o_cmd_ready  out  1  command FIFO not full
- i_cmd_kind  in  2  0=IO_WRITE, 1=IO_READ, 2=MEM_WRITE_1, 3=MEM_READ_1
- i_cmd_addr  in  16  bus address
- i_cmd_data  in  8  write data (ignored for reads)
- i_cmd_len  in  8  burst length-1 (used only with HARZQ_BURST_EN)
- o_rsp_valid  out  1  response FIFO not empty
- i_rsp_ready  in  1  response pop strobe
- o_rsp_data  out  8  head read data
- o_rsp_err  out  1  head entry produced by timeout
- o_request  out  harz_req_t  HARZ80 request to MMU
- o_address  out  16  HARZ80 address
- o_write_data  out  8  HARZ80 write data
- i_read_data  in  8  HARZ80 read data
- i_busy  in  1  HARZ80 busy from MMU
- o_idle  out  1  command FIFO empty and FSM in IDLE
- o_timeout_err  out  1  sticky timeout flag
- i_err_clr  in  1  clears o_timeout_err

Behaviour:
- Interface: one clock, i_CLK. Reset i_RST is synchronous and active-high.
- Reset values:
  - o_request=HARZ80_NONE; o_address=0; o_write_data=0
  - both FIFOs empty; o_rsp_valid=0; o_rsp_data=0; o_rsp_err=0
  - o_timeout_err=0; o_idle=1; FSM=IDLE
  - Reset mid-transaction drops o_request to NONE on the next edge and discards all queued entries.
- Command FIFO:
  - Push when i_cmd_valid&o_cmd_ready. Push while full is ignored.
  - Simultaneous push and pop when full is allowed, because the pop frees space the same cycle.
- FSM (all outputs registered):
  - IDLE: if the command FIFO is non-empty, and the head is a write or the response FIFO has space counting in-flight reads, load o_address/o_write_data, drive the mapped o_request, and go to ISSUE. A read whose response FIFO is full stalls in IDLE.
  - ISSUE: hold o_request until i_busy=1 is sampled. That cycle drive o_request=NONE and go to WAIT_DONE. Holding request across a stale busy=0 is required, because the MMU samples only in its idle state.
  - WAIT_DONE: on i_busy=0, capture i_read_data. Reads push {err=0, data} to the response FIFO. Pop the command (or advance the burst). Go to GAP.
  - GAP: one cycle, request=NONE, covering the MMU finish cycle. Then IDLE.
- Minimum issue-to-issue spacing is 5 cycles with an MMU delay of 0.
- Timeout:
  - A counter resets on entering ISSUE and counts in ISSUE and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1: set o_timeout_err, drive NONE, and for reads push {err=1, data=8'hFF`}. Pop the command and go to GAP.
- i_err_clr clears o_timeout_err. A timeout in the same cycle wins (flag stays 1).
- Response FIFO pops on o_rsp_valid&i_rsp_ready. Push and pop in the same cycle are both honoured.

Optional Feature:
- HARZQ_BURST_EN defined:
  - The entry carries i_cmd_len. The command repeats len+1 times before being popped.
  - MEM kinds increment the address by 1 per beat, wrapping 16'hFFFF→16'h0000. IO kinds keep the address fixed.
  - Write beats reuse i_cmd_data.
  - A timeout aborts the remaining beats of that entry.
- HARZQ_BURST_EN undefined: i_cmd_len is ignored and not stored; every entry is a single transaction.

Test Plan:
- Push MEM_WRITE_1 addr 16'h8000 data 8'h5A; model MMU asserts busy 1 cycle after request and drops it 3 cycles later → request seen for exactly the cycles up to busy=1; no response entry; o_idle=1 after GAP.
- Push IO_READ addr 16'h00A0; MMU returns 8'h3C → one response with data 8'h3C, err 0; o_request=NONE throughout WAIT_DONE.
- Fill the response FIFO with 8 reads, don't pop, push a 9th read → 9th not issued (o_request stays NONE) until one pop, then it issues.
- MMU never asserts busy on MEM_READ_1 → after 1024 cycles o_timeout_err=1, response {err=1, 8'hFF}; the next queued write issues normally; i_err_clr clears the flag.
- Assert i_RST while in WAIT_DONE with 3 commands queued → next cycle o_request=NONE, o_idle=1, o_cmd_ready=1, o_rsp_valid=0.
- With HARZQ_BURST_EN, MEM_READ_1 addr 16'hFFFE len 2 → addresses FFFE, FFFF, 0000 issued in order, 3 responses.
